// File: rtl/usb_line_pkg.sv
// usb_line_pkg: shared state encoding and default timing for the USB line controller.
// Timing constants assume a 15 MHz sampling clock.
package usb_line_pkg;

    typedef enum logic [2:0] {
        ST_DETACHED    = 3'd0,
        ST_ATTACH_WAIT = 3'd1,
        ST_ACTIVE      = 3'd2,
        ST_SUSPEND     = 3'd3,
        ST_WAKEUP      = 3'd4
    } line_state_e;

    localparam int DEF_ATTACH_CYC  = 15000;
    localparam int DEF_RESET_CYC   = 38;
    localparam int DEF_SUSPEND_CYC = 45000;
    localparam int DEF_WAKE_K_CYC  = 150000;

    function automatic int max4(int a, int b, int c, int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/usb_line_if.sv
// usb_line_if: transmitter request / transceiver drive bundle.
// master = line controller side, slave = packet transmitter side.
interface usb_line_if;
    logic tx_oe;
    logic tx_j_not_k;
    logic tx_se0;
    logic tx_grant;
    logic usb_oe;
    logic usb_j_not_k;
    logic usb_se0;

    modport master (
        input  tx_oe, tx_j_not_k, tx_se0,
        output tx_grant, usb_oe, usb_j_not_k, usb_se0
    );

    modport slave (
        output tx_oe, tx_j_not_k, tx_se0,
        input  tx_grant, usb_oe, usb_j_not_k, usb_se0
    );
endinterface

// File: rtl/usb_line_sync.sv
// usb_line_sync: two-flop synchronizer for the raw receive line state.
// Resets to idle J with SE0 low.
module usb_line_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_j_not_k,
    input  logic i_se0,
    output logic o_j_not_k,
    output logic o_se0
);
    logic [1:0] r_j;
    logic [1:0] r_se0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_j   <= 2'b11;
            r_se0 <= 2'b00;
        end else begin
            r_j   <= {r_j[0], i_j_not_k};
            r_se0 <= {r_se0[0], i_se0};
        end
    end

    assign o_j_not_k = r_j[1];
    assign o_se0     = r_se0[1];
endmodule

// File: rtl/usb_line_ctrl.sv
// usb_line_ctrl: USB device line-state controller (attach, bus reset, suspend).
// Define USB_REMOTE_WAKEUP_EN to add the remote-wakeup K drive from suspend.
module usb_line_ctrl
    import usb_line_pkg::*;
#(
    parameter int ATTACH_CYC  = DEF_ATTACH_CYC,
    parameter int RESET_CYC   = DEF_RESET_CYC,
    parameter int SUSPEND_CYC = DEF_SUSPEND_CYC,
    parameter int WAKE_K_CYC  = DEF_WAKE_K_CYC
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic       i_usb_j_not_k,
    input  logic       i_usb_se0,
    input  logic       i_tx_oe,
    input  logic       i_tx_j_not_k,
    input  logic       i_tx_se0,
    input  logic       i_wakeup_req,
    output logic       o_usb_oe,
    output logic       o_usb_j_not_k,
    output logic       o_usb_se0,
    output logic       o_usb_attach,
    output logic       o_tx_grant,
    output logic       o_bus_reset,
    output logic       o_suspended,
    output logic [2:0] o_state
);
    localparam int CW =
        $clog2(max4(ATTACH_CYC, RESET_CYC, SUSPEND_CYC, WAKE_K_CYC)) + 1;

    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t CNT_MAX = '1;

    logic        w_j;
    logic        w_se0;
    line_state_e r_state;
    line_state_e w_next;
    cnt_t        r_cnt;
    cnt_t        r_se0_cnt;
    cnt_t        r_idle_cnt;
    logic        r_bus_reset;
    logic        w_line_idle;
    logic        w_watch_se0;
    logic        w_se0_run;
    logic        w_se0_hit;
    logic        w_idle_done;
    logic        w_attach_done;
    logic        w_resume;

    usb_line_sync u_sync (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_j_not_k (i_usb_j_not_k),
        .i_se0     (i_usb_se0),
        .o_j_not_k (w_j),
        .o_se0     (w_se0)
    );

    // Our own transmit echo must never look like idle J or a host reset.
    assign w_line_idle   = w_j && !w_se0 && !i_tx_oe;
    assign w_watch_se0   = i_enable &&
                           (r_state == ST_ACTIVE || r_state == ST_SUSPEND);
    assign w_se0_run     = w_watch_se0 && w_se0 && !i_tx_oe;
    assign w_se0_hit     = w_se0_run && (r_se0_cnt == cnt_t'(RESET_CYC - 1));
    assign w_idle_done   = w_line_idle &&
                           (r_idle_cnt == cnt_t'(SUSPEND_CYC - 1));
    assign w_attach_done = (r_cnt == cnt_t'(ATTACH_CYC - 1));
    assign w_resume      = !w_j || w_se0;

`ifdef USB_REMOTE_WAKEUP_EN
    logic w_wake_done;
    assign w_wake_done = (r_cnt == cnt_t'(WAKE_K_CYC - 1));
`else
    logic w_unused_wake;
    assign w_unused_wake = i_wakeup_req;
`endif

    always_comb begin
        w_next = r_state;
        if (!i_enable) begin
            w_next = ST_DETACHED;
        end else begin
            unique case (r_state)
                ST_DETACHED:    w_next = ST_ATTACH_WAIT;
                ST_ATTACH_WAIT: if (w_attach_done) w_next = ST_ACTIVE;
                ST_ACTIVE:      if (w_idle_done) w_next = ST_SUSPEND;
                ST_SUSPEND: begin
                    if (w_resume) w_next = ST_ACTIVE;
`ifdef USB_REMOTE_WAKEUP_EN
                    else if (i_wakeup_req) w_next = ST_WAKEUP;
`endif
                end
`ifdef USB_REMOTE_WAKEUP_EN
                ST_WAKEUP:      if (w_wake_done) w_next = ST_ACTIVE;
`else
                ST_WAKEUP:      w_next = ST_ACTIVE;
`endif
                default:        w_next = ST_DETACHED;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_DETACHED;
        else          r_state <= w_next;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt       <= '0;
            r_se0_cnt   <= '0;
            r_idle_cnt  <= '0;
            r_bus_reset <= 1'b0;
        end else begin
            if (w_next != r_state)   r_cnt <= '0;
            else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;

            // SE0 run survives the SUSPEND->ACTIVE hop so resume-by-reset still pulses.
            if (!w_se0_run)                r_se0_cnt <= '0;
            else if (r_se0_cnt != CNT_MAX) r_se0_cnt <= r_se0_cnt + 1'b1;

            if (!(i_enable && r_state == ST_ACTIVE && w_line_idle))
                r_idle_cnt <= '0;
            else if (r_idle_cnt != CNT_MAX)
                r_idle_cnt <= r_idle_cnt + 1'b1;

            r_bus_reset <= w_se0_hit;
        end
    end

    always_comb begin
        o_usb_oe      = 1'b0;
        o_usb_j_not_k = 1'b1;
        o_usb_se0     = 1'b0;
        o_tx_grant    = 1'b0;
        unique case (r_state)
            ST_ACTIVE: begin
                o_tx_grant    = 1'b1;
                o_usb_oe      = i_tx_oe;
                o_usb_j_not_k = i_tx_j_not_k;
                o_usb_se0     = i_tx_se0;
            end
            ST_WAKEUP: begin
                o_usb_oe      = 1'b1;
                o_usb_j_not_k = 1'b0;
            end
            default: ;
        endcase
    end

    assign o_usb_attach = (r_state != ST_DETACHED);
    assign o_suspended  = (r_state == ST_SUSPEND);
    assign o_bus_reset  = r_bus_reset;
    assign o_state      = r_state;
endmodule

// File: tb/tb_usb_line_ctrl.sv
// tb_usb_line_ctrl: self-checking bench for usb_line_ctrl with short timing.
// Bus-reset pulses are predicted into a queue and matched against the DUT.
module tb_usb_line_ctrl;
    import usb_line_pkg::*;

    localparam int ATT = 5;
    localparam int RST = 4;
    localparam int SUS = 20;
    localparam int WAK = 8;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       enable   = 1'b0;
    logic       line_j   = 1'b1;
    logic       line_se0 = 1'b0;
    logic       wake_req = 1'b0;
    logic       attach;
    logic       bus_reset;
    logic       suspended;
    logic [2:0] st;

    int unsigned cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int unsigned exp_q[$];

    typedef struct {
        logic oe, j, se0;
        logic e_oe, e_j, e_se0;
    } vec_t;
    vec_t tbl[6];

    usb_line_if bus ();

    usb_line_ctrl #(
        .ATTACH_CYC (ATT),
        .RESET_CYC  (RST),
        .SUSPEND_CYC(SUS),
        .WAKE_K_CYC (WAK)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enable     (enable),
        .i_usb_j_not_k(line_j),
        .i_usb_se0    (line_se0),
        .i_tx_oe      (bus.tx_oe),
        .i_tx_j_not_k (bus.tx_j_not_k),
        .i_tx_se0     (bus.tx_se0),
        .i_wakeup_req (wake_req),
        .o_usb_oe     (bus.usb_oe),
        .o_usb_j_not_k(bus.usb_j_not_k),
        .o_usb_se0    (bus.usb_se0),
        .o_usb_attach (attach),
        .o_tx_grant   (bus.tx_grant),
        .o_bus_reset  (bus_reset),
        .o_suspended  (suspended),
        .o_state      (st)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic chk3(input string nm, input logic [2:0] act, input logic [2:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic step_mon();
        int unsigned e;
        @(posedge clk);
        #1;
        if (bus_reset === 1'b1) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL bus_reset_unexpected: got pulse at cycle %0d expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                if (e == cyc) n_pass++;
                else $display("FAIL bus_reset_time: got cycle %0d expected cycle %0d", cyc, e);
            end
        end
    endtask

    task automatic set_tx(input logic oe, input logic j, input logic se0);
        bus.tx_oe      = oe;
        bus.tx_j_not_k = j;
        bus.tx_se0     = se0;
    endtask

    task automatic chk_q_empty(input string nm);
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL %s: got %0d pulses outstanding expected 0", nm, exp_q.size());
    endtask

    task automatic wait_susp(input int lim);
        for (int i = 0; i < lim && suspended !== 1'b1; i++) step_mon();
        chk1("wait_suspend", suspended, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        set_tx(1'b0, 1'b1, 1'b0);

        step_mon();
        step_mon();
        chk3("rst_state", st, ST_DETACHED);
        chk1("rst_attach", attach, 1'b0);
        chk1("rst_oe", bus.usb_oe, 1'b0);
        chk1("rst_j", bus.usb_j_not_k, 1'b1);
        chk1("rst_grant", bus.tx_grant, 1'b0);
        chk1("rst_bus_reset", bus_reset, 1'b0);
        chk1("rst_suspended", suspended, 1'b0);
        rst_n = 1'b1;

        line_j = 1'b0;
        enable = 1'b1;
        step_mon();
        chk1("attach_c1", attach, 1'b1);
        chk3("attach_wait_c1", st, ST_ATTACH_WAIT);
        for (int i = 0; i < ATT - 1; i++) step_mon();
        chk3("attach_wait_last", st, ST_ATTACH_WAIT);
        step_mon();
        chk3("active_after_attach", st, ST_ACTIVE);

        wake_req = 1'b1;
        step_mon();
        wake_req = 1'b0;
        chk3("wake_ignored_active", st, ST_ACTIVE);

        for (int i = 0; i < 6; i++) begin
            set_tx(tbl[i].oe, tbl[i].j, tbl[i].se0);
            #1;
            chk1("mirror_oe", bus.usb_oe, tbl[i].e_oe);
            chk1("mirror_j", bus.usb_j_not_k, tbl[i].e_j);
            chk1("mirror_se0", bus.usb_se0, tbl[i].e_se0);
            chk1("mirror_grant", bus.tx_grant, 1'b1);
        end

        set_tx(1'b1, 1'b0, 1'b1);
        line_se0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step_mon();
            chk1("echo_oe", bus.usb_oe, 1'b1);
            chk1("echo_se0", bus.usb_se0, 1'b1);
        end
        chk3("echo_state", st, ST_ACTIVE);
        set_tx(1'b0, 1'b1, 1'b0);
        line_se0 = 1'b0;
        for (int i = 0; i < 3; i++) step_mon();

        line_se0 = 1'b1;
        exp_q.push_back(cyc + 2 + RST);
        for (int i = 0; i < 12; i++) step_mon();
        line_se0 = 1'b0;
        for (int i = 0; i < 4; i++) step_mon();
        chk_q_empty("bus_reset_missing");
        chk3("after_reset_state", st, ST_ACTIVE);

        line_j = 1'b1;
        for (int i = 0; i < 2 + SUS - 1; i++) step_mon();
        chk1("idle_not_yet", suspended, 1'b0);
        step_mon();
        chk1("idle_suspend", suspended, 1'b1);
        chk3("suspend_state", st, ST_SUSPEND);
        set_tx(1'b1, 1'b0, 1'b0);
        #1;
        chk1("suspend_oe", bus.usb_oe, 1'b0);
        chk1("suspend_grant", bus.tx_grant, 1'b0);
        set_tx(1'b0, 1'b1, 1'b0);

        line_j = 1'b0;
        step_mon();
        line_j = 1'b1;
        step_mon();
        chk3("resume_k_c2", st, ST_SUSPEND);
        step_mon();
        chk3("resume_k_c3", st, ST_ACTIVE);
        chk1("resume_unsusp", suspended, 1'b0);

        wait_susp(40);
`ifdef USB_REMOTE_WAKEUP_EN
        set_tx(1'b1, 1'b1, 1'b1);
        wake_req = 1'b1;
        step_mon();
        wake_req = 1'b0;
        for (int i = 0; i < WAK; i++) begin
            chk3("wake_state", st, ST_WAKEUP);
            chk1("wake_oe", bus.usb_oe, 1'b1);
            chk1("wake_j", bus.usb_j_not_k, 1'b0);
            chk1("wake_se0", bus.usb_se0, 1'b0);
            step_mon();
        end
        chk3("wake_done", st, ST_ACTIVE);
        set_tx(1'b0, 1'b1, 1'b0);

        wait_susp(40);
        wake_req = 1'b1;
        step_mon();
        wake_req = 1'b0;
        step_mon();
        step_mon();
        chk1("wake_mid_oe", bus.usb_oe, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("rst_mid_wake_oe", bus.usb_oe, 1'b0);
        chk3("rst_mid_wake_state", st, ST_DETACHED);
        chk1("rst_mid_wake_attach", attach, 1'b0);
`else
        wake_req = 1'b1;
        step_mon();
        wake_req = 1'b0;
        for (int i = 0; i < WAK + 1; i++) begin
            chk3("nowake_state", st, ST_SUSPEND);
            chk1("nowake_oe", bus.usb_oe, 1'b0);
            step_mon();
        end

        line_j = 1'b0;
        for (int i = 0; i < 3; i++) step_mon();
        chk3("tx_resume", st, ST_ACTIVE);
        set_tx(1'b1, 1'b0, 1'b0);
        #1;
        chk1("tx_mid_oe", bus.usb_oe, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("rst_mid_tx_oe", bus.usb_oe, 1'b0);
        chk1("rst_mid_tx_grant", bus.tx_grant, 1'b0);
        chk3("rst_mid_tx_state", st, ST_DETACHED);
        set_tx(1'b0, 1'b1, 1'b0);
`endif
        step_mon();
        rst_n = 1'b1;
        line_j = 1'b0;

        for (int i = 0; i < 10 && st !== ST_ACTIVE; i++) step_mon();
        chk3("reattach_active", st, ST_ACTIVE);
        enable = 1'b0;
        set_tx(1'b1, 1'b0, 1'b1);
        line_se0 = 1'b1;
        step_mon();
        chk3("disable_state", st, ST_DETACHED);
        chk1("disable_attach", attach, 1'b0);
        chk1("disable_oe", bus.usb_oe, 1'b0);
        for (int i = 0; i < 6; i++) step_mon();
        chk3("disable_hold", st, ST_DETACHED);
        chk_q_empty("final_queue");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/usb_line_ctrl.md
USB_LINE_CTRL -- requirements
Module: usb_line_ctrl

Interface
REQ-001 SHALL have parameter ATTACH_CYC, default 15000, cycles from enable to ACTIVE (1 ms at 15 MHz).
REQ-002 SHALL have parameter RESET_CYC, default 38, minimum SE0 run flagged as bus reset (2.5 us).
REQ-003 SHALL have parameter SUSPEND_CYC, default 45000, idle-J run that enters suspend (3 ms).
REQ-004 SHALL have parameter WAKE_K_CYC, default 150000, remote-wakeup K duration (10 ms).
REQ-005 SHALL have ports, in order:
 i_clk  in  1  single clock (15 MHz nominal)
 i_rst_n  in  1  reset, asynchronous, active-low
 i_enable  in  1  attach request
 i_usb_j_not_k  in  1  raw receive line state
 i_usb_se0  in  1  raw receive SE0
 i_tx_oe  in  1  packet transmitter drive request
 i_tx_j_not_k  in  1  packet transmitter symbol
 i_tx_se0  in  1  packet transmitter SE0
 i_wakeup_req  in  1  one-cycle remote-wakeup request
 o_usb_oe  out  1  transceiver output enable
 o_usb_j_not_k  out  1  driven symbol
 o_usb_se0  out  1  driven SE0
 o_usb_attach  out  1  pull-up enable
 o_tx_grant  out  1  transmitter owns bus
 o_bus_reset  out  1  one-cycle bus-reset pulse
 o_suspended  out  1  suspend level
 o_state  out  3  current state encoding

Function
REQ-006 SHALL pass i_usb_j_not_k/i_usb_se0 through a 2-flop synchronizer; all detection uses synchronized values (2-cycle latency).
REQ-007 SHALL implement states DETACHED, ATTACH_WAIT, ACTIVE, SUSPEND, WAKEUP.
REQ-008 SHALL, from any state, go to DETACHED next cycle when i_enable=0.
REQ-009 DETACHED: attach=0, oe=0; i_enable=1 -> ATTACH_WAIT, counter cleared.
REQ-010 ATTACH_WAIT: attach=1; after exactly ATTACH_CYC cycles -> ACTIVE.
REQ-011 ACTIVE: o_tx_grant=1; o_usb_* equal i_tx_* combinationally (zero latency).
REQ-012 ACTIVE: o_bus_reset pulses one cycle when synchronized SE0 has been high RESET_CYC consecutive cycles; at most one pulse per SE0 run.
REQ-013 ACTIVE: idle counter increments on synchronized J with SE0=0 and i_tx_oe=0; clears on K, SE0, or i_tx_oe=1; reaching SUSPEND_CYC -> SUSPEND.
REQ-014 SE0 and idle counters SHALL be held cleared while i_tx_oe=1 (own echo ignored).
REQ-015 SUSPEND: o_suspended=1, oe=0, grant=0; synchronized K or SE0 -> ACTIVE next cycle; i_wakeup_req -> WAKEUP (macro enabled only).
REQ-016 SUSPEND: SE0 persisting RESET_CYC cycles SHALL also produce o_bus_reset once (via ACTIVE).
REQ-017 WAKEUP: oe=1, j_not_k=0, se0=0 for exactly WAKE_K_CYC cycles, then ACTIVE; i_tx_* ignored; received line ignored.
REQ-018 Outside ACTIVE/WAKEUP: o_usb_oe=0, o_usb_j_not_k=1, o_usb_se0=0, grant=0.
REQ-019 Simultaneous i_enable fall and any other event: DETACHED wins; i_wakeup_req outside SUSPEND ignored.
REQ-020 Counter width SHALL be $clog2 of largest parameter plus 1; counters saturate, never wrap.

Reset
REQ-021 On i_rst_n=0: state DETACHED, all counters and synchronizer flops cleared (synchronizer to J, SE0=0), o_usb_oe=0, o_usb_attach=0, o_tx_grant=0, o_bus_reset=0, o_suspended=0.
REQ-022 Reset asserted mid-WAKEUP or mid-transmit SHALL release the bus within the same cycle (asynchronous).

Configuration
REQ-023 Macro USB_REMOTE_WAKEUP_EN defined: WAKEUP state and i_wakeup_req path present; undefined: i_wakeup_req ignored, WAKEUP unreachable, its counter logic removed, port retained.

Structure
REQ-024 Package usb_line_pkg SHALL hold the state enum/encoding and default timing constants.
REQ-025 Synchronizer SHALL be sub-module usb_line_sync.

Verification (ATTACH_CYC=5, RESET_CYC=4, SUSPEND_CYC=20, WAKE_K_CYC=8)
REQ-026 Enable at cycle 0 -> attach=1 cycle 1, ACTIVE after 5 cycles; enable low -> DETACHED, attach=0 next cycle.
REQ-027 ACTIVE, SE0 held 10 cycles -> exactly one o_bus_reset pulse 4 cycles after synchronized SE0 rises.
REQ-028 ACTIVE, J idle 20 cycles -> o_suspended=1; single K -> ACTIVE 2+1 cycles later.
REQ-029 SUSPEND, i_wakeup_req pulse -> K driven exactly 8 cycles, then ACTIVE; macro undefined -> no drive.
REQ-030 i_tx_oe=1 with SE0 echo for 10 cycles -> no o_bus_reset, no suspend, o_usb_* mirror i_tx_* same cycle.
REQ-031 Reset asserted mid-WAKEUP -> o_usb_oe=0 immediately, state DETACHED.
